// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program counter and instruction-fetch stage. The PC addresses a narrow
//   external bus that returns an instruction as BEATS beats of BUS_W bits,
//   MSB beat first. The assembled instruction is presented to decode/execute
//   until execute pulses step. On step, the PC advances to PC+1 or loads the
//   ALU target, as chosen by the branch unit's pc_sel.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   pc_sel       1 = PC+1, 0 = load target (sampled on the step edge in EXEC)
//   target       jump/branch target from the ALU
//   step         execute done; commit next PC (sampled only in EXEC)
//   bus_data     fetch beat data
//   bus_valid    bus_data valid this cycle (sampled only in FETCH)
//   fetch_req    fetch in progress; addr and beat are valid
//   addr         current PC / fetch address
//   beat         index of the beat expected next, 0 = MSB beat
//   instr        assembled instruction
//   instr_valid  instr is complete and stable
module pc_fetch_unit #(
  parameter  int PC_W    = 6,
  parameter  int INSTR_W = 16,
  parameter  int BUS_W   = 8,
  localparam int BEATS   = INSTR_W / BUS_W,
  localparam int BEAT_W  = (BEATS > 2) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_sel,
  input  logic [PC_W-1:0]    target,
  input  logic               step,
  input  logic [BUS_W-1:0]   bus_data,
  input  logic               bus_valid,
  output logic               fetch_req,
  output logic [PC_W-1:0]    addr,
  output logic [BEAT_W-1:0]  beat,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t          state;
  logic [PC_W-1:0] pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      beat  <= '0;
      instr <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          // Shift beats in from the LSB end so the first beat lands on top.
          if (bus_valid) begin
            instr <= {instr[INSTR_W-BUS_W-1:0], bus_data};
            if (beat == LAST_BEAT) begin
              beat  <= '0;
              state <= EXEC;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        EXEC: begin
          // pc+1 truncates to PC_W, so the top address wraps to 0.
          if (step) begin
            pc    <= pc_sel ? pc + 1'b1 : target;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decodes of registered state.
  assign fetch_req   = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign addr        = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Directed steps followed by a randomized run. A spec-level model tracks
//   which phase the fetch stage is in, the PC, how many beats have arrived
//   and the assembled instruction; every cycle all DUT outputs are compared
//   with it, and the directed steps add constant expectations on top.
module tb_pc_fetch_unit;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 16;
  localparam int BUS_W   = 8;
  localparam int BEATS   = INSTR_W / BUS_W;
  localparam int BEAT_W  = (BEATS > 2) ? $clog2(BEATS) : 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               pc_sel;
  logic [PC_W-1:0]    target;
  logic               step;
  logic [BUS_W-1:0]   bus_data;
  logic               bus_valid;
  logic               fetch_req;
  logic [PC_W-1:0]    addr;
  logic [BEAT_W-1:0]  beat;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = waiting one cycle after reset,
  // 1 = collecting beats, 2 = holding an instruction for execute.
  int m_phase;
  int m_pc;
  int m_nbeats;
  int m_instr;

  pc_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .BUS_W(BUS_W)) dut (
    .clk(clk), .reset(reset), .pc_sel(pc_sel), .target(target), .step(step),
    .bus_data(bus_data), .bus_valid(bus_valid), .fetch_req(fetch_req),
    .addr(addr), .beat(beat), .instr(instr), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_phase = 0; m_pc = 0; m_nbeats = 0; m_instr = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (bus_valid) begin
        m_instr  = ((m_instr * (1 << BUS_W)) + int'(bus_data)) % (1 << INSTR_W);
        m_nbeats = m_nbeats + 1;
        if (m_nbeats == BEATS) begin
          m_nbeats = 0;
          m_phase  = 2;
        end
      end
    end else if (step) begin
      m_pc    = pc_sel ? (m_pc + 1) % (1 << PC_W) : int'(target);
      m_phase = 1;
    end
  endtask

  task automatic model_check();
    chk("fetch_req", int'(fetch_req), int'(m_phase == 1));
    chk("instr_valid", int'(instr_valid), int'(m_phase == 2));
    chk("addr", int'(addr), m_pc);
    chk("beat", int'(beat), m_nbeats);
    chk("instr", int'(instr), m_instr);
  endtask

  // One clock: drive inputs, model the edge, sample 1 time unit later.
  task automatic cyc(input logic r, input logic st, input logic sel,
                     input int tgt, input logic bv, input int d);
    reset = r; step = st; pc_sel = sel;
    target = PC_W'(tgt); bus_valid = bv; bus_data = BUS_W'(d);
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic fetch_word(input int w);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, (w >> 8) & 8'hFF);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, w & 8'hFF);
  endtask

  task automatic do_step(input logic sel, input int tgt);
    cyc(1'b0, 1'b1, sel, tgt, 1'b0, 0);
  endtask

  int saved;

  initial begin
    reset = 1'b1; step = 1'b0; pc_sel = 1'b0; target = '0;
    bus_valid = 1'b0; bus_data = '0;
    m_phase = 0; m_pc = 0; m_nbeats = 0; m_instr = 0;

    // 1. Reset for two cycles, then release.
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    chk("rst_fetch_req", int'(fetch_req), 0);
    chk("rst_instr_valid", int'(instr_valid), 0);
    chk("rst_addr", int'(addr), 0);
    reset = 1'b0;
    #1;
    chk("rel_cycle1_fetch_req", int'(fetch_req), 0);
    idle_cyc();
    chk("rel_cycle2_fetch_req", int'(fetch_req), 1);
    chk("rel_cycle2_addr", int'(addr), 0);
    chk("rel_cycle2_beat", int'(beat), 0);

    // 2. Back-to-back beats, then sequential step.
    fetch_word(16'hA53C);
    chk("t2_instr", int'(instr), 16'hA53C);
    chk("t2_instr_valid", int'(instr_valid), 1);
    do_step(1'b1, 0);
    chk("t2_addr", int'(addr), 1);
    chk("t2_fetch_req", int'(fetch_req), 1);
    chk("t2_instr_valid_low", int'(instr_valid), 0);

    // 3. Gap between beats; step during FETCH is ignored.
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 8'h12);
    idle_cyc();
    cyc(1'b0, 1'b1, 1'b0, 6'h33, 1'b0, 8'hEE);
    idle_cyc();
    chk("t3_beat_hold", int'(beat), 1);
    chk("t3_addr_hold", int'(addr), 1);
    chk("t3_not_valid", int'(instr_valid), 0);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 8'h34);
    chk("t3_instr", int'(instr), 16'h1234);
    chk("t3_instr_valid", int'(instr_valid), 1);

    // 4. Walk to addr 5, then jump to 0x2A with step held two cycles.
    for (int i = 0; i < 4; i++) begin
      do_step(1'b1, 0);
      fetch_word(16'h0100 + i);
    end
    chk("t4_at5", int'(addr), 5);
    do_step(1'b0, 6'h2A);
    do_step(1'b0, 6'h10);
    chk("t4_target", int'(addr), 6'h2A);
    chk("t4_single_advance", int'(fetch_req), 1);

    // 5. Wrap from 63 to 0.
    fetch_word(16'hBEEF);
    do_step(1'b0, 63);
    fetch_word(16'hCAFE);
    chk("t5_at63", int'(addr), 63);
    do_step(1'b1, 0);
    chk("t5_wrap", int'(addr), 0);

    // 6. Reset mid-fetch at addr 9, restart, then bus noise in EXEC.
    fetch_word(16'h5A5A);
    do_step(1'b0, 9);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 8'h77);
    chk("t6_at9", int'(addr), 9);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    chk("t6_pc", int'(addr), 0);
    chk("t6_beat", int'(beat), 0);
    chk("t6_instr", int'(instr), 0);
    chk("t6_fetch_req", int'(fetch_req), 0);
    idle_cyc();
    chk("t6_restart", int'(fetch_req), 1);
    fetch_word(16'h9C3D);
    saved = int'(instr);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, $urandom_range(255));
    chk("t6_exec_hold", int'(instr), 16'h9C3D);
    chk("t6_exec_valid", int'(instr_valid), 1);

    // 7. Randomized traffic against the model.
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(99) < 2), ($urandom_range(3) == 0), $urandom_range(1),
          $urandom_range(63), $urandom_range(1), $urandom_range(255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
